// File: rtl/keycode_event_queue.sv
// Debounced keycode level -> press/release events in a show-ahead FIFO.
// Define KEYCODE_TYPEMATIC_EN to add auto-repeat press events.
module keycode_event_queue #(
   parameter int DEPTH        = 8,
   parameter int DEBOUNCE_CYC = 4,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset_n,
   input  logic [7:0]             keycode_in,
   input  logic                   evt_ready,
   input  logic                   clr_overflow,
   output logic                   evt_valid,
   output logic [7:0]             evt_code,
   output logic                   evt_press,
   output logic                   evt_repeat,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow
);

   typedef enum logic [1:0] {
      IDLE,
      EMIT_REL,
      EMIT_PRS
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       press;
      logic       rpt;
   } evt_t;

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_CYC - 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 ||
       REPEAT_RATE < 1) begin : g_bad_cfg
      $error("keycode_event_queue: bad parameters");
   end

   state_t        state_q;
   state_t        state_d;
   logic [7:0]    kc_q;
   logic [7:0]    committed;
   logic [7:0]    prev_code;
   logic [SW-1:0] stab_cnt;
   logic          commit;
   logic          rpt_push;
   logic          push;
   logic          push_ok;
   logic          pop;
   logic          full;
   evt_t          push_evt;
   evt_t          head;
   evt_t          mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   // stability counter saturates once the debounce window is met
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         kc_q     <= 8'h00;
         stab_cnt <= '0;
      end else begin
         kc_q <= keycode_in;
         if (keycode_in != kc_q)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + 1'b1;
      end
   end

   assign commit = (state_q == IDLE) &&
                   (kc_q != committed) &&
                   (stab_cnt == STAB_MAX);

   always_comb begin
      state_d  = state_q;
      push     = 1'b0;
      push_evt = '0;
      unique case (state_q)
         IDLE: begin
            if (commit) begin
               state_d = (committed != 8'h00) ?
                         EMIT_REL : EMIT_PRS;
            end else if (rpt_push) begin
               push           = 1'b1;
               push_evt.code  = committed;
               push_evt.press = 1'b1;
               push_evt.rpt   = 1'b1;
            end
         end
         EMIT_REL: begin
            push          = 1'b1;
            push_evt.code = prev_code;
            state_d = (committed != 8'h00) ?
                      EMIT_PRS : IDLE;
         end
         EMIT_PRS: begin
            push           = 1'b1;
            push_evt.code  = committed;
            push_evt.press = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q   <= IDLE;
         committed <= 8'h00;
         prev_code <= 8'h00;
      end else begin
         state_q <= state_d;
         if (commit) begin
            prev_code <= committed;
            committed <= kc_q;
         end
      end
   end

`ifdef KEYCODE_TYPEMATIC_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                         REPEAT_DELAY : REPEAT_RATE;
   localparam int RW = $clog2(RMAX + 1);

   logic [RW-1:0] rpt_cnt;
   logic [RW-1:0] rpt_lim;
   logic          rpt_armed;
   logic          rpt_run;

   assign rpt_run  = (state_q == IDLE) &&
                     (committed != 8'h00) && !commit;
   assign rpt_lim  = rpt_armed ? RW'(REPEAT_RATE - 1) :
                                 RW'(REPEAT_DELAY - 1);
   assign rpt_push = rpt_run && (rpt_cnt == rpt_lim);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n || commit) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else if (rpt_push) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b1;
      end else if (rpt_run) begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end
`else
   assign rpt_push = 1'b0;
`endif

   // count range is 0..DEPTH, so the MSB alone flags full
   assign fifo_count = wr_ptr - rd_ptr;
   assign full       = fifo_count[AW];
   assign evt_valid  = (fifo_count != '0);
   assign pop        = evt_valid && evt_ready;
   assign push_ok    = push && (!full || pop);
   assign head       = mem[rd_ptr[AW-1:0]];
   assign evt_code   = evt_valid ? head.code : 8'h00;
   assign evt_press  = evt_valid && head.press;
   assign evt_repeat = evt_valid && head.rpt;

   always_ff @(posedge clk_clk) begin
      if (push_ok)
         mem[wr_ptr[AW-1:0]] <= push_evt;
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !push_ok)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keycode_event_queue.sv
// Scoreboard bench for keycode_event_queue (DEPTH=8, DEBOUNCE_CYC=4).
module tb_keycode_event_queue;

   logic       clk_clk       = 1'b0;
   logic       reset_reset_n = 1'b0;
   logic [7:0] keycode_in    = 8'h00;
   logic       evt_ready     = 1'b0;
   logic       clr_overflow  = 1'b0;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_press;
   logic       evt_repeat;
   logic [3:0] fifo_count;
   logic       overflow;

   int vectors     = 0;
   int miscompares = 0;

   // expected entries {code, press, repeat}
   logic [9:0] sb [$];
   logic [9:0] exp_e;
   logic [9:0] got_e;

   always #5 clk_clk = ~clk_clk;

   keycode_event_queue #(
      .DEPTH(8),
      .DEBOUNCE_CYC(4),
      .REPEAT_DELAY(20),
      .REPEAT_RATE(5)
   ) dut (
      .clk_clk(clk_clk),
      .reset_reset_n(reset_reset_n),
      .keycode_in(keycode_in),
      .evt_ready(evt_ready),
      .clr_overflow(clr_overflow),
      .evt_valid(evt_valid),
      .evt_code(evt_code),
      .evt_press(evt_press),
      .evt_repeat(evt_repeat),
      .fifo_count(fifo_count),
      .overflow(overflow)
   );

   assign got_e = {evt_code, evt_press, evt_repeat};

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   task automatic test_reset();
      reset_reset_n = 1'b0;
      tick(2);
      vectors++;
      if (evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset valid: got %b want 0", evt_valid);
      end
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL reset count: got %0d want 0", fifo_count);
      end
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset overflow: got %b want 0", overflow);
      end
      vectors++;
      if (got_e !== 10'h000) begin
         miscompares++;
         $display("FAIL reset head: got %h want 000", got_e);
      end
      reset_reset_n = 1'b1;
      tick(2);
   endtask

   task automatic test_latency();
      keycode_in = 8'h1A;
      sb.push_back({8'h1A, 1'b1, 1'b0});
      tick(5);
      vectors++;
      if (evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL latency early: got %b want 0", evt_valid);
      end
      tick();
      vectors++;
      if (evt_valid !== 1'b1 || fifo_count !== 4'd1) begin
         miscompares++;
         $display("FAIL latency valid/count: got %b/%0d want 1/1",
                  evt_valid, fifo_count);
      end
      exp_e = sb.pop_front();
      vectors++;
      if (got_e !== exp_e) begin
         miscompares++;
         $display("FAIL latency head: got %h want %h", got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL latency pop: got %0d want 0", fifo_count);
      end
   endtask

   task automatic test_change();
      keycode_in = 8'h04;
      sb.push_back({8'h1A, 1'b0, 1'b0});
      sb.push_back({8'h04, 1'b1, 1'b0});
      tick(5);
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL change c5: got %0d want 0", fifo_count);
      end
      tick();
      vectors++;
      if (fifo_count !== 4'd1) begin
         miscompares++;
         $display("FAIL change c6: got %0d want 1", fifo_count);
      end
      tick();
      vectors++;
      if (fifo_count !== 4'd2) begin
         miscompares++;
         $display("FAIL change c7: got %0d want 2", fifo_count);
      end
      for (int k = 0; k < 4 && sb.size() != 0; k++) begin
         exp_e = sb.pop_front();
         vectors++;
         if (evt_valid !== 1'b1 || got_e !== exp_e) begin
            miscompares++;
            $display("FAIL change drain: got %b/%h want 1/%h",
                     evt_valid, got_e, exp_e);
         end
         evt_ready = 1'b1;
         tick();
         evt_ready = 1'b0;
      end
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL change empty: got %0d want 0", fifo_count);
      end
   endtask

   task automatic test_glitch();
      keycode_in = 8'h00;
      tick(2);
      keycode_in = 8'h3B;
      tick(3);
      keycode_in = 8'h04;
      tick(8);
      vectors++;
      if (fifo_count !== 4'd0 || evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch: got %0d/%b want 0/0",
                  fifo_count, evt_valid);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5];
      logic [7:0] prev;
      codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      prev  = 8'h04;
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         keycode_in = codes[i];
         if (sb.size() < 8) sb.push_back({prev, 1'b0, 1'b0});
         if (sb.size() < 8) sb.push_back({codes[i], 1'b1, 1'b0});
         prev = codes[i];
         tick(8);
      end
      vectors++;
      if (fifo_count !== 4'd8) begin
         miscompares++;
         $display("FAIL ovf count: got %0d want 8", fifo_count);
      end
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf flag: got %b want 1", overflow);
      end
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      vectors++;
      if (overflow !== 1'b0 || fifo_count !== 4'd8) begin
         miscompares++;
         $display("FAIL ovf clear: got %b/%0d want 0/8",
                  overflow, fifo_count);
      end
   endtask

   task automatic test_full_push_pop();
      keycode_in = 8'h66;
      sb.push_back({8'h55, 1'b0, 1'b0});
      sb.push_back({8'h66, 1'b1, 1'b0});
      tick(5);
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd8 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL full c5: got %0d/%h want 8/%h",
                  fifo_count, got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick();
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd8 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL full c6: got %0d/%h want 8/%h",
                  fifo_count, got_e, exp_e);
      end
      tick();
      evt_ready = 1'b0;
      vectors++;
      if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL full c7: got %0d/%b want 8/0",
                  fifo_count, overflow);
      end
      for (int k = 0; k < 12 && sb.size() != 0; k++) begin
         exp_e = sb.pop_front();
         vectors++;
         if (evt_valid !== 1'b1 || got_e !== exp_e) begin
            miscompares++;
            $display("FAIL full drain: got %b/%h want 1/%h",
                     evt_valid, got_e, exp_e);
         end
         evt_ready = 1'b1;
         tick();
         evt_ready = 1'b0;
      end
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL full empty: got %0d want 0", fifo_count);
      end
   endtask

   task automatic test_reset_mid_emit();
      keycode_in = 8'h77;
      tick(5);
      reset_reset_n = 1'b0;
      tick();
      vectors++;
      if (fifo_count !== 4'd0 || evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst: got %0d/%b want 0/0",
                  fifo_count, evt_valid);
      end
      reset_reset_n = 1'b1;
      sb.push_back({8'h77, 1'b1, 1'b0});
      tick(5);
      vectors++;
      if (evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst early: got %b want 0", evt_valid);
      end
      tick();
      exp_e = sb.pop_front();
      vectors++;
      if (evt_valid !== 1'b1 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL midrst press: got %b/%h want 1/%h",
                  evt_valid, got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask

   task automatic test_release_empty_ready();
      keycode_in = 8'h00;
      sb.push_back({8'h77, 1'b0, 1'b0});
      tick(6);
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd1 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL release: got %0d/%h want 1/%h",
                  fifo_count, got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick(4);
      vectors++;
      if (fifo_count !== 4'd0 || evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL empty ready: got %0d/%b want 0/0",
                  fifo_count, evt_valid);
      end
      evt_ready = 1'b0;
   endtask

`ifdef KEYCODE_TYPEMATIC_EN
   task automatic test_typematic();
      keycode_in = 8'h2C;
      sb.push_back({8'h2C, 1'b1, 1'b0});
      sb.push_back({8'h2C, 1'b1, 1'b1});
      sb.push_back({8'h2C, 1'b1, 1'b1});
      sb.push_back({8'h2C, 1'b0, 1'b0});
      tick(6);
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd1 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL rpt press: got %0d/%h want 1/%h",
                  fifo_count, got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      tick(18);
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL rpt early: got %0d want 0", fifo_count);
      end
      tick();
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd1 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL rpt first: got %0d/%h want 1/%h",
                  fifo_count, got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      tick(3);
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL rpt gap: got %0d want 0", fifo_count);
      end
      tick();
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd1 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL rpt second: got %0d/%h want 1/%h",
                  fifo_count, got_e, exp_e);
      end
      evt_ready  = 1'b1;
      keycode_in = 8'h00;
      tick();
      evt_ready = 1'b0;
      tick(4);
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL rpt vs commit: got %0d want 0", fifo_count);
      end
      tick();
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd1 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL rpt release: got %0d/%h want 1/%h",
                  fifo_count, got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask
`else
   task automatic test_no_repeat();
      keycode_in = 8'h5A;
      sb.push_back({8'h5A, 1'b1, 1'b0});
      tick(6);
      exp_e = sb.pop_front();
      vectors++;
      if (fifo_count !== 4'd1 || got_e !== exp_e) begin
         miscompares++;
         $display("FAIL norpt press: got %0d/%h want 1/%h",
                  fifo_count, got_e, exp_e);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      tick(40);
      vectors++;
      if (fifo_count !== 4'd0 || evt_repeat !== 1'b0) begin
         miscompares++;
         $display("FAIL norpt hold: got %0d/%b want 0/0",
                  fifo_count, evt_repeat);
      end
      keycode_in = 8'h00;
      tick(8);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      test_reset();
      test_latency();
      test_change();
      test_glitch();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_emit();
      test_release_empty_ready();
`ifdef KEYCODE_TYPEMATIC_EN
      test_typematic();
`else
      test_no_repeat();
`endif
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
